// File: rtl/alu_operand_stage_if.sv
// Handshake bundle around the ALU operand stage: decode request, writeback bypass, ALU result, ALU-side issue.
// master = surrounding pipeline (decode, ALU, writeback); slave = the operand stage. ALU_OP_AMT sets the op width.
`ifndef ALU_OP_AMT
`define ALU_OP_AMT 8
`endif

interface alu_operand_stage_if #(
  parameter int data_bus_size = 8,
  parameter int reg_addr_size = 3
);
  localparam int op_size = $clog2(`ALU_OP_AMT);

  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [op_size-1:0]       in_op;
  logic [reg_addr_size-1:0] in_rs_a;
  logic [reg_addr_size-1:0] in_rs_b;
  logic [data_bus_size-1:0] in_rf_a;
  logic [data_bus_size-1:0] in_rf_b;
  logic                     in_use_imm;
  logic [data_bus_size-1:0] in_imm;
  logic [reg_addr_size-1:0] in_rd;
  logic                     in_wr_en;
  logic [data_bus_size-1:0] alu_result;
  logic                     wb_wr_en;
  logic [reg_addr_size-1:0] wb_rd;
  logic [data_bus_size-1:0] wb_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [data_bus_size-1:0] out_a;
  logic [data_bus_size-1:0] out_b;
  logic [op_size-1:0]       out_op;
  logic [reg_addr_size-1:0] out_rd;
  logic                     out_wr_en;

  modport master (
    output flush, in_valid, in_op, in_rs_a, in_rs_b, in_rf_a, in_rf_b,
           in_use_imm, in_imm, in_rd, in_wr_en, alu_result,
           wb_wr_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_op, out_rd, out_wr_en
  );

  modport slave (
    input  flush, in_valid, in_op, in_rs_a, in_rs_b, in_rf_a, in_rf_b,
           in_use_imm, in_imm, in_rd, in_wr_en, alu_result,
           wb_wr_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_op, out_rd, out_wr_en
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-select pipeline register feeding the ALU; EX/WB hazard resolution, bypass when FORWARDING_EN is defined.
// Latency: 1 cycle accept -> out_valid, 1 instr/cycle when out_ready=1 and no hazard.
// Backpressure: holds all outputs while out_ready=0; in_ready drops on full-and-stalled, hazard or flush.
`ifndef ALU_OP_AMT
`define ALU_OP_AMT 8
`endif

module alu_operand_stage #(
  parameter int data_bus_size = 8,
  parameter int reg_addr_size = 3
) (
  input logic                clk,
  input logic                rst_n,
  alu_operand_stage_if.slave bus
);
  localparam int op_size = $clog2(`ALU_OP_AMT);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [data_bus_size-1:0] a;
    logic [data_bus_size-1:0] b;
    logic [op_size-1:0]       op;
    logic [reg_addr_size-1:0] rd;
    logic                     wr_en;
  } held_t;

  state_t state, state_nxt;
  held_t  held, held_nxt;

  logic                     can_load;
  logic                     accept;
  logic                     hazard;
  logic                     ex_match_a, ex_match_b;
  logic                     wb_match_a, wb_match_b;
  logic [data_bus_size-1:0] opnd_a, opnd_b;

  // B matches are masked by in_use_imm: rs_b is a don't-care for immediate forms.
  assign ex_match_a = (state == FULL) & held.wr_en & (held.rd == bus.in_rs_a);
  assign ex_match_b = (state == FULL) & held.wr_en & (held.rd == bus.in_rs_b) & ~bus.in_use_imm;
  assign wb_match_a = bus.wb_wr_en & (bus.wb_rd == bus.in_rs_a);
  assign wb_match_b = bus.wb_wr_en & (bus.wb_rd == bus.in_rs_b) & ~bus.in_use_imm;

`ifdef FORWARDING_EN
  // EX wins over WB: it is the younger write to the same register.
  always_comb begin
    opnd_a = bus.in_rf_a;
    if (ex_match_a)      opnd_a = bus.alu_result;
    else if (wb_match_a) opnd_a = bus.wb_data;

    opnd_b = bus.in_rf_b;
    if (bus.in_use_imm)  opnd_b = bus.in_imm;
    else if (ex_match_b) opnd_b = bus.alu_result;
    else if (wb_match_b) opnd_b = bus.wb_data;
  end

  // alu_result is only final once the held instruction is leaving.
  assign hazard = (ex_match_a | ex_match_b) & ~bus.out_ready;
`else
  logic unused_bypass;

  assign opnd_a        = bus.in_rf_a;
  assign opnd_b        = bus.in_use_imm ? bus.in_imm : bus.in_rf_b;
  assign hazard        = ex_match_a | ex_match_b | wb_match_a | wb_match_b;
  assign unused_bypass = ^{bus.alu_result, bus.wb_data};
`endif

  assign can_load     = (state == EMPTY) | bus.out_ready;
  assign bus.in_ready = can_load & ~hazard & ~bus.flush;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (!accept && bus.out_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
    if (bus.flush) state_nxt = EMPTY;
  end

  // Payload only moves on accept; while EMPTY it keeps the last value.
  always_comb begin
    held_nxt = held;
    if (accept) begin
      held_nxt.a     = opnd_a;
      held_nxt.b     = opnd_b;
      held_nxt.op    = bus.in_op;
      held_nxt.rd    = bus.in_rd;
      held_nxt.wr_en = bus.in_wr_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held <= '0;
    end else begin
      held <= held_nxt;
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_a     = held.a;
  assign bus.out_b     = held.b;
  assign bus.out_op    = held.op;
  assign bus.out_rd    = held.rd;
  assign bus.out_wr_en = held.wr_en;

  hold_under_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (state == FULL) && !bus.out_ready && !bus.flush |=> (state == FULL) && $stable(held));

  no_accept_on_flush: assert property (@(posedge clk) disable iff (!rst_n)
    bus.flush |-> !bus.in_ready);

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: forwarding/stall, backpressure, flush and async reset.
// Expected values are hand-computed; the ALU is a small op table driven from the held operands.
`ifndef ALU_OP_AMT
`define ALU_OP_AMT 8
`endif

module tb_alu_operand_stage;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fails  = 0;

  alu_operand_stage_if #(.data_bus_size(8), .reg_addr_size(3)) bus ();

  alu_operand_stage #(.data_bus_size(8), .reg_addr_size(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1:    return a;
      3'd2:    return a + b;
      3'd3:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  assign bus.alu_result = alu_model(bus.out_op, bus.out_a, bus.out_b);

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] rs_a, input logic [2:0] rs_b,
                       input logic [7:0] rf_a, input logic [7:0] rf_b, input logic use_imm,
                       input logic [7:0] imm, input logic [2:0] rd, input logic wr_en);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rs_a    = rs_a;
    bus.in_rs_b    = rs_b;
    bus.in_rf_a    = rf_a;
    bus.in_rf_b    = rf_b;
    bus.in_use_imm = use_imm;
    bus.in_imm     = imm;
    bus.in_rd      = rd;
    bus.in_wr_en   = wr_en;
  endtask

  task automatic set_wb(input logic en, input logic [2:0] rd, input logic [7:0] data);
    bus.wb_wr_en = en;
    bus.wb_rd    = rd;
    bus.wb_data  = data;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid  = 1'b0;
    set_wb(0, 0, 0);

    repeat (2) @(negedge clk);
    chk_val("rst_vld", bus.out_valid, 0);
    chk_val("rst_a",   bus.out_a,     0);
    chk_val("rst_b",   bus.out_b,     0);
    chk_val("rst_op",  bus.out_op,    0);
    chk_val("rst_rd",  bus.out_rd,    0);
    chk_val("rst_wr",  bus.out_wr_en, 0);
    rst_n = 1'b1;
    #1 chk_val("rst_rdy", bus.in_ready, 1);

    // R1 = 5 + 3
    @(negedge clk);
    drive(2, 5, 6, 8'd5, 8'd3, 0, 8'd0, 1, 1);
    #1 chk_val("add_rdy", bus.in_ready, 1);
    @(negedge clk);
    chk_val("add_vld", bus.out_valid, 1);
    chk_val("add_a",   bus.out_a,     8'd5);
    chk_val("add_b",   bus.out_b,     8'd3);
    chk_val("add_op",  bus.out_op,    2);
    chk_val("add_rd",  bus.out_rd,    1);
    chk_val("add_wr",  bus.out_wr_en, 1);

    // R2 = R1 - 1 with a stale register-file value for R1
    drive(3, 1, 0, 8'd0, 8'd0, 1, 8'd1, 2, 1);
`ifdef FORWARDING_EN
    #1 chk_val("dep_rdy", bus.in_ready, 1);
    @(negedge clk);
`else
    #1 chk_val("dep_rdy_ex", bus.in_ready, 0);
    @(negedge clk);
    chk_val("dep_drain", bus.out_valid, 0);
    set_wb(1, 1, 8'd8);
    #1 chk_val("dep_rdy_wb", bus.in_ready, 0);
    @(negedge clk);
    set_wb(0, 0, 0);
    bus.in_rf_a = 8'd8;
    #1 chk_val("dep_rdy_clr", bus.in_ready, 1);
    @(negedge clk);
`endif
    chk_val("dep_vld", bus.out_valid, 1);
    chk_val("dep_a",   bus.out_a,     8'd8);
    chk_val("dep_b",   bus.out_b,     8'd1);

    // rs_a hits writeback; rs_b names the held rd but is masked by the immediate
    drive(1, 4, 2, 8'd0, 8'd0, 1, 8'd0, 5, 0);
    set_wb(1, 4, 8'h3C);
`ifdef FORWARDING_EN
    #1 chk_val("wb_rdy", bus.in_ready, 1);
    @(negedge clk);
`else
    #1 chk_val("wb_rdy_stall", bus.in_ready, 0);
    @(negedge clk);
    set_wb(0, 0, 0);
    bus.in_rf_a = 8'h3C;
    #1 chk_val("wb_rdy_clr", bus.in_ready, 1);
    @(negedge clk);
`endif
    set_wb(0, 0, 0);
    chk_val("wb_a", bus.out_a, 8'h3C);
    chk_val("wb_b", bus.out_b, 8'h00);

    // R2 = 0x10 + 1, then a reader of R2 while writeback also targets R2
    drive(2, 0, 0, 8'h10, 8'd0, 1, 8'd1, 2, 1);
    @(negedge clk);
    chk_val("pri_ld", bus.out_a, 8'h10);
    drive(1, 2, 0, 8'd0, 8'd0, 1, 8'd0, 3, 0);
    set_wb(1, 2, 8'h22);
`ifdef FORWARDING_EN
    #1 chk_val("pri_rdy", bus.in_ready, 1);
    @(negedge clk);
`else
    #1 chk_val("pri_rdy_stall", bus.in_ready, 0);
    @(negedge clk);
    set_wb(0, 0, 0);
    bus.in_rf_a = 8'h11;
    #1 chk_val("pri_rdy_clr", bus.in_ready, 1);
    @(negedge clk);
`endif
    set_wb(0, 0, 0);
    chk_val("pri_a", bus.out_a, 8'h11);

    // Backpressure: rs_b equals held rd but held wr_en=0, so no hazard
    drive(2, 1, 3, 8'h21, 8'h12, 0, 8'd0, 6, 1);
    @(negedge clk);
    chk_val("bp_ld", bus.out_a, 8'h21);
    bus.out_ready = 1'b0;
    drive(4, 7, 0, 8'h55, 8'd0, 1, 8'h0F, 7, 1);
    #1 chk_val("bp_rdy0", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_val("bp_vld",  bus.out_valid, 1);
      chk_val("bp_a",    bus.out_a,     8'h21);
      chk_val("bp_b",    bus.out_b,     8'h12);
      chk_val("bp_rdy",  bus.in_ready,  0);
    end
    bus.out_ready = 1'b1;
    #1 chk_val("bp_rdy1", bus.in_ready, 1);
    @(negedge clk);
    chk_val("bp_next_a",  bus.out_a,  8'h55);
    chk_val("bp_next_b",  bus.out_b,  8'h0F);
    chk_val("bp_next_op", bus.out_op, 4);

`ifdef FORWARDING_EN
    // Reader of R7 while the R7 producer is stalled, then released
    bus.out_ready = 1'b0;
    drive(2, 7, 0, 8'd0, 8'd0, 1, 8'd1, 1, 1);
    #1 chk_val("exst_rdy0", bus.in_ready, 0);
    @(negedge clk);
    chk_val("exst_hold", bus.out_a, 8'h55);
    bus.out_ready = 1'b1;
    #1 chk_val("exst_rdy1", bus.in_ready, 1);
    @(negedge clk);
    chk_val("exst_a", bus.out_a, 8'h5A);
`endif

    // Flush while full, stalled and presenting a dependent instruction
    drive(1, 0, 0, 8'h77, 8'd0, 1, 8'd0, 4, 1);
    @(negedge clk);
    chk_val("fl_ld", bus.out_a, 8'h77);
    bus.out_ready = 1'b0;
    drive(1, 4, 0, 8'h99, 8'd0, 1, 8'd0, 5, 1);
    bus.flush = 1'b1;
    #1 chk_val("fl_rdy", bus.in_ready, 0);
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk_val("fl_vld",  bus.out_valid, 0);
    chk_val("fl_a",    bus.out_a,     8'h77);
    @(negedge clk);
    chk_val("fl_vld2", bus.out_valid, 0);
    bus.out_ready = 1'b1;

    // Async reset with a held instruction
    drive(2, 0, 0, 8'hA5, 8'h5A, 0, 8'd0, 6, 1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk_val("mr_vld_pre", bus.out_valid, 1);
    chk_val("mr_a_pre",   bus.out_a,     8'hA5);
    rst_n = 1'b0;
    #1;
    chk_val("mr_vld", bus.out_valid, 0);
    chk_val("mr_a",   bus.out_a,     0);
    chk_val("mr_b",   bus.out_b,     0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk_val("mr_rdy", bus.in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Pipeline register and operand-selection stage directly upstream of the ALU. Accepts a decoded instruction plus register-file read data, resolves read-after-write hazards against the instruction in the ALU and the one in writeback, and presents registered A, B, op and destination info to the ALU. It uses a valid/ready handshake on both sides, stalls decode when operands are not resolvable, and supports a synchronous flush.

## Interface
- data_bus_size, 8, width of A, B and all data paths
- reg_addr_size, 3, width of register addresses
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of held and incoming instruction
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_op  in  $clog2(`ALU_OP_AMT)  ALU operation encoding
- in_rs_a, in_rs_b  in  reg_addr_size  source register addresses
- in_rf_a, in_rf_b  in  data_bus_size  register-file read data (pre-write values)
- in_use_imm  in  1  B taken from in_imm; rs_b ignored
- in_imm  in  data_bus_size  immediate
- in_rd  in  reg_addr_size  destination register
- in_wr_en  in  1  instruction writes rd
- alu_result  in  data_bus_size  combinational ALU output for held instruction
- wb_wr_en  in  1  writeback writes this cycle
- wb_rd  in  reg_addr_size  writeback destination
- wb_data  in  data_bus_size  writeback data
- out_valid  out  1  A/B/op valid to ALU
- out_ready  in  1  downstream accepts held instruction
- out_a, out_b  out  data_bus_size  ALU operands
- out_op  out  $clog2(`ALU_OP_AMT)  ALU operation
- out_rd  out  reg_addr_size  destination
- out_wr_en  out  1  destination write enable

## Operation
- Clock/reset decided: one clock clk; rst_n asynchronous, active-low.
- Two states per held slot: EMPTY (out_valid=0), FULL (out_valid=1).
- can_load = ~out_valid | out_ready. in_ready = can_load & ~hazard & ~flush.
- Accept (in_valid & in_ready): registers load selected operands, in_op, in_rd, in_wr_en; out_valid<=1.
- FULL & out_ready & no accept: out_valid<=0. FULL & ~out_ready: all outputs hold.
- EX match per source: out_valid & out_wr_en & out_rd==rs. WB match: wb_wr_en & wb_rd==rs.
- Operand select (forwarding): EX match -> alu_result; else WB match -> wb_data; else in_rf. EX has priority over WB. B source is in_imm when in_use_imm (no matching on rs_b).
- hazard = 0 with forwarding, except EX match while ~out_ready (held result not final): stall.
- Register 0 is not special; all addresses compared.
- flush: out_valid<=0 next edge, incoming instruction dropped, in_ready=0 that cycle. Flush overrides accept and hold.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle with out_ready=1 and no stall.
- Reset values: out_valid=0, out_a=0, out_b=0, out_op=0, out_rd=0, out_wr_en=0.
- in_ready is combinational from out_valid, out_ready, flush and hazard match logic.
- Reset asserted mid-operation discards the held instruction immediately (async).
- When out_valid=0, data outputs keep last value; ALU consumers qualify with out_valid.

## Configuration
- FORWARDING_EN defined: bypass paths as above; only stall is EX match with ~out_ready.
- FORWARDING_EN undefined: no bypass; operands always in_rf/in_imm. hazard = any EX match or WB match on a used source; in_ready=0 until clear (RF is updated the edge after wb_wr_en).

## Test plan
- Reset: rst_n low mid-stream with out_valid=1 -> out_valid=0, out_a=out_b=0 immediately; in_ready=1 after release.
- Back-to-back, FORWARDING_EN: R1=5+3 (op 2) then R2=R1-1 (op 3, imm 1), in_rf_a stale 0 -> second out_a=8 (from alu_result), out_b=1, no stall cycle.
- WB forward: wb_wr_en=1, wb_rd=4, wb_data=0x3C, instruction reads rs_a=4 with in_rf_a=0 -> out_a=0x3C.
- Priority: EX and WB both target R2 (alu_result=0x11, wb_data=0x22) -> out_a=0x11.
- Backpressure: out_ready=0 for 3 cycles while FULL -> outputs stable, in_ready=0; out_ready=1 -> next instruction loads next edge.
- Without FORWARDING_EN: dependent instruction on R1 -> in_ready low 2 cycles (EX then WB match), then accepted with in_rf_a=8; flush during stall -> out_valid=0, nothing accepted.
